arp_request_parser: RTL and testbench
=====================================

ARP_REQUEST_PARSER -- requirements
Module: arp_request_parser

Interface
REQ-001 SHALL have parameter MAX_FRAME, default 1518, maximum accepted frame length in bytes (destination MAC through FCS inclusive).
REQ-002 SHALL have port clock  in  1  single clock; rx data sampled on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port BOARD_MAC  in  48  own MAC; quasi-static.
REQ-005 SHALL have port BOARD_IP  in  32  own IPv4 address; quasi-static.
REQ-006 SHALL have port rx_dv  in  1  receive data valid from PHY.
REQ-007 SHALL have port rxd  in  4  receive nibble, low nibble of each byte first.
REQ-008 SHALL have port PC_MAC  out  48  sender hardware address of last accepted request.
REQ-009 SHALL have port PC_IP  out  32  sender protocol address of last accepted request.
REQ-010 SHALL have port req_valid  out  1  one-cycle pulse per accepted ARP request; drives the ARP reply former's ena.
REQ-011 SHALL have port crc_err  out  1  one-cycle pulse per frame failing FCS check.
REQ-012 SHALL have port busy  out  1  high while not in IDLE.

Function
REQ-013 SHALL use states WAIT_GAP, IDLE, PREAMBLE, DATA, DROP.
REQ-014 WAIT_GAP -> IDLE when rx_dv sampled 0; IDLE -> PREAMBLE when rx_dv=1 and rxd=4'h5; IDLE with rx_dv=1, rxd!=5 -> DROP.
REQ-015 PREAMBLE: rxd=5 stay; rxd=4'hD -> DATA; any other nibble -> DROP; rx_dv=0 -> IDLE.
REQ-016 DATA: nibbles paired into bytes, first nibble = bits[3:0], second = bits[7:4]; 11-bit byte counter from 0 at first byte after SFD.
REQ-017 Byte-index checks: 0-5 == FF:FF:FF:FF:FF:FF or BOARD_MAC; 12-13 == 08 06; 14-15 == 00 01; 16-17 == 08 00; 18 == 06; 19 == 04; 20-21 == 00 01; 38-41 == BOARD_IP (MSB first); any mismatch clears an internal match flag; bytes 32-37 and 42+ unchecked.
REQ-018 Bytes 22-27 SHALL be captured as candidate MAC (byte 22 -> [47:40]) and 28-31 as candidate IP (byte 28 -> [31:24]).
REQ-019 CRC: reflected CRC-32 (poly 0xEDB88320), init 0xFFFFFFFF, LSB-first, over every byte from index 0 through last FCS byte; frame good iff final register == 0xDEBB20E3.
REQ-020 Byte count reaching MAX_FRAME+1 -> DROP, no pulses.
REQ-021 End of frame = first sampled rx_dv=0 in DATA; next state IDLE.
REQ-022 At end of frame, with byte count >= 64, even nibble count, CRC good and match flag set: PC_MAC/PC_IP load candidates and req_valid =1 for exactly the next cycle.
REQ-023 At end of frame with byte count >= 64, even nibble count and CRC bad: crc_err =1 for exactly the next cycle; PC_MAC/PC_IP unchanged.
REQ-024 Runt (<64 bytes) or odd nibble count: silently discarded; no pulses.
REQ-025 DROP -> IDLE when rx_dv sampled 0; no pulses emitted from DROP.
REQ-026 req_valid and crc_err SHALL never be high in the same cycle.
REQ-027 One idle cycle (rx_dv=0) between frames SHALL suffice to receive the next frame.
REQ-028 PC_MAC/PC_IP SHALL hold value until next accepted request.

Reset
REQ-029 reset SHALL asynchronously force state WAIT_GAP, counters 0, CRC register 0xFFFFFFFF, match flag 0, PC_MAC=0, PC_IP=0, req_valid=0, crc_err=0.
REQ-030 Frame in progress at reset SHALL be discarded; reception resumes only after rx_dv seen low.

Verification
REQ-031 Broadcast ARP request, BOARD_IP=C0A8010A, TPA=C0A8010A, SHA=001122334455, SPA=C0A80164, 18 pad bytes, correct FCS -> one-cycle req_valid, PC_MAC=48'h001122334455, PC_IP=32'hC0A80164.
REQ-032 Same frame, one FCS bit flipped -> crc_err one cycle, no req_valid, PC_MAC/PC_IP unchanged.
REQ-033 Same frame with TPA=C0A8010B, or oper=00 02, correct FCS -> no req_valid, no crc_err.
REQ-034 reset pulsed at byte 30, released with rx_dv still high -> frame ignored; following valid frame after 1 idle cycle -> req_valid.
REQ-035 Two valid frames, SPA C0A80164 then C0A80165, one idle cycle apart -> two req_valid pulses; final PC_IP=C0A80165.
REQ-036 60-byte runt and 1519-byte frame -> no pulses; busy returns low after rx_dv falls.

Source files
------------

// File: rtl/arp_request_parser.sv
// arp_request_parser: MII receive-side parser that detects ARP requests for BOARD_IP and checks the FCS.
// Ports:
//    clock, reset        : single clock, asynchronous active-high reset
//    BOARD_MAC, BOARD_IP : own addresses (quasi-static)
//    rx_dv, rxd          : MII receive data valid and nibble (low nibble of each byte first)
//    PC_MAC, PC_IP       : sender addresses of the last accepted request
//    req_valid           : one-cycle pulse per accepted ARP request
//    crc_err             : one-cycle pulse per full-length frame with a bad FCS
//    busy                : high whenever the parser is not in IDLE
module arp_request_parser #(
   parameter int MAX_FRAME = 1518
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [47:0] BOARD_MAC,
   input  logic [31:0] BOARD_IP,
   input  logic        rx_dv,
   input  logic [3:0]  rxd,
   output logic [47:0] PC_MAC,
   output logic [31:0] PC_IP,
   output logic        req_valid,
   output logic        crc_err,
   output logic        busy
);
   typedef enum logic [2:0] {WAIT_GAP, IDLE, PREAMBLE, DATA, DROP} state_t;

   localparam logic [10:0] LIMIT   = 11'(MAX_FRAME + 1);
   localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

   state_t      state_q;
   logic [10:0] cnt_q;
   logic        odd_q;
   logic [3:0]  lo_q;
   logic [31:0] crc_q;
   logic        match_q, bc_q, me_q;
   logic [47:0] cand_mac_q;
   logic [31:0] cand_ip_q;

   logic [7:0]  byte_d, exp_d, own_d;
   logic        chk_d, full_d;
   logic [10:0] cnt_d;
   logic [31:0] crc_d;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
      return r;
   endfunction

   assign byte_d = {rxd, lo_q};
   assign cnt_d  = cnt_q + 11'd1;
   assign crc_d  = crc_byte(crc_q, byte_d);
   assign full_d = cnt_q >= 11'd64 && !odd_q;
   assign busy   = state_q != IDLE;

   // Fixed-value header fields and the target protocol address
   always_comb begin
      chk_d = 1'b1;
      case (cnt_q)
         11'd12:  exp_d = 8'h08;
         11'd13:  exp_d = 8'h06;
         11'd14:  exp_d = 8'h00;
         11'd15:  exp_d = 8'h01;
         11'd16:  exp_d = 8'h08;
         11'd17:  exp_d = 8'h00;
         11'd18:  exp_d = 8'h06;
         11'd19:  exp_d = 8'h04;
         11'd20:  exp_d = 8'h00;
         11'd21:  exp_d = 8'h01;
         11'd38:  exp_d = BOARD_IP[31:24];
         11'd39:  exp_d = BOARD_IP[23:16];
         11'd40:  exp_d = BOARD_IP[15:8];
         11'd41:  exp_d = BOARD_IP[7:0];
         default: begin
            exp_d = 8'h00;
            chk_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      case (cnt_q[2:0])
         3'd0:    own_d = BOARD_MAC[47:40];
         3'd1:    own_d = BOARD_MAC[39:32];
         3'd2:    own_d = BOARD_MAC[31:24];
         3'd3:    own_d = BOARD_MAC[23:16];
         3'd4:    own_d = BOARD_MAC[15:8];
         default: own_d = BOARD_MAC[7:0];
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= WAIT_GAP;
         cnt_q      <= '0;
         odd_q      <= 1'b0;
         lo_q       <= '0;
         crc_q      <= '1;
         match_q    <= 1'b0;
         bc_q       <= 1'b0;
         me_q       <= 1'b0;
         cand_mac_q <= '0;
         cand_ip_q  <= '0;
         PC_MAC     <= '0;
         PC_IP      <= '0;
         req_valid  <= 1'b0;
         crc_err    <= 1'b0;
      end else begin
         req_valid <= 1'b0;
         crc_err   <= 1'b0;
         case (state_q)
            WAIT_GAP: if (!rx_dv) state_q <= IDLE;
            IDLE:     if (rx_dv) state_q <= (rxd == 4'h5) ? PREAMBLE : DROP;
            PREAMBLE: begin
               if (!rx_dv) state_q <= IDLE;
               else if (rxd == 4'hD) begin
                  state_q <= DATA;
                  cnt_q   <= '0;
                  odd_q   <= 1'b0;
                  crc_q   <= '1;
                  match_q <= 1'b1;
                  bc_q    <= 1'b1;
                  me_q    <= 1'b1;
               end else if (rxd != 4'h5) state_q <= DROP;
            end
            DATA: begin
               if (!rx_dv) begin
                  state_q <= IDLE;
                  // Destination must be broadcast or our own MAC
                  if (full_d && crc_q == RESIDUE && match_q && (bc_q || me_q)) begin
                     PC_MAC    <= cand_mac_q;
                     PC_IP     <= cand_ip_q;
                     req_valid <= 1'b1;
                  end
                  crc_err <= full_d && crc_q != RESIDUE;
               end else if (!odd_q) begin
                  lo_q  <= rxd;
                  odd_q <= 1'b1;
               end else begin
                  odd_q <= 1'b0;
                  cnt_q <= cnt_d;
                  crc_q <= crc_d;
                  if (cnt_q < 11'd6) begin
                     bc_q <= bc_q && byte_d == 8'hFF;
                     me_q <= me_q && byte_d == own_d;
                  end
                  if (chk_d && byte_d != exp_d) match_q <= 1'b0;
                  if (cnt_q >= 11'd22 && cnt_q <= 11'd27) cand_mac_q <= {cand_mac_q[39:0], byte_d};
                  if (cnt_q >= 11'd28 && cnt_q <= 11'd31) cand_ip_q <= {cand_ip_q[23:0], byte_d};
                  if (cnt_d == LIMIT) state_q <= DROP;
               end
            end
            DROP:    if (!rx_dv) state_q <= IDLE;
            default: state_q <= WAIT_GAP;
         endcase
      end
   end
endmodule

// File: tb/tb_arp_request_parser.sv
// tb_arp_request_parser: directed checks of ARP request parsing, FCS checking, length limits and reset recovery.
module tb_arp_request_parser;
   localparam logic [47:0] MY_MAC = 48'h02AABBCCDDEE;
   localparam logic [31:0] MY_IP  = 32'hC0A8010A;
   localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;
   localparam logic [47:0] SHA    = 48'h001122334455;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rx_dv = 1'b0;
   logic [3:0]  rxd = 4'h0;
   logic [47:0] PC_MAC;
   logic [31:0] PC_IP;
   logic        req_valid, crc_err, busy;

   int n_cmp = 0;
   int n_bad = 0;
   int rv_rise = 0, rv_hi = 0, ce_rise = 0, ce_hi = 0, both_hi = 0;
   logic rv_p = 1'b0, ce_p = 1'b0;
   logic busy_at_abort = 1'b0;
   logic [7:0] frm[$];

   arp_request_parser #(.MAX_FRAME(1518)) dut (
      .clock(clock), .reset(reset), .BOARD_MAC(MY_MAC), .BOARD_IP(MY_IP),
      .rx_dv(rx_dv), .rxd(rxd), .PC_MAC(PC_MAC), .PC_IP(PC_IP),
      .req_valid(req_valid), .crc_err(crc_err), .busy(busy)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (req_valid && !rv_p) rv_rise++;
      if (crc_err && !ce_p) ce_rise++;
      if (req_valid) rv_hi++;
      if (crc_err) ce_hi++;
      if (req_valid && crc_err) both_hi++;
      rv_p = req_valid;
      ce_p = crc_err;
   end

   task automatic build(input logic [47:0] dst, input logic [15:0] oper, input logic [31:0] spa,
                        input logic [31:0] tpa, input int len);
      logic [31:0] c;
      frm.delete();
      for (int i = 5; i >= 0; i--) frm.push_back(dst[8*i+:8]);
      for (int i = 5; i >= 0; i--) frm.push_back(SHA[8*i+:8]);
      frm.push_back(8'h08); frm.push_back(8'h06); frm.push_back(8'h00); frm.push_back(8'h01);
      frm.push_back(8'h08); frm.push_back(8'h00); frm.push_back(8'h06); frm.push_back(8'h04);
      frm.push_back(oper[15:8]); frm.push_back(oper[7:0]);
      for (int i = 5; i >= 0; i--) frm.push_back(SHA[8*i+:8]);
      for (int i = 3; i >= 0; i--) frm.push_back(spa[8*i+:8]);
      for (int i = 0; i < 6; i++) frm.push_back(8'h00);
      for (int i = 3; i >= 0; i--) frm.push_back(tpa[8*i+:8]);
      while (frm.size() < len - 4) frm.push_back(8'h00);
      c = 32'hFFFFFFFF;
      foreach (frm[i])
         for (int k = 0; k < 8; k++)
            c = (c[0] ^ frm[i][k]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      c = ~c;
      frm.push_back(c[7:0]); frm.push_back(c[15:8]); frm.push_back(c[23:16]); frm.push_back(c[31:24]);
   endtask

   task automatic nib(input logic [3:0] n);
      @(negedge clock);
      rx_dv = 1'b1;
      rxd = n;
   endtask

   task automatic send_frame(input int idle, input int abort_at, input bit odd);
      repeat (15) nib(4'h5);
      nib(4'hD);
      foreach (frm[i]) begin
         if (i == abort_at) begin
            @(posedge clock);
            #2 reset = 1'b1;
            #1 reset = 1'b0;
            busy_at_abort = busy;
         end
         nib(frm[i][3:0]);
         nib(frm[i][7:4]);
      end
      if (odd) nib(4'h7);
      @(negedge clock);
      rx_dv = 1'b0;
      rxd = 4'h0;
      repeat (idle - 1) @(negedge clock);
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clock);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy got %b want 1", busy); end
      n_cmp++; if (PC_MAC !== 48'h0) begin n_bad++; $display("FAIL reset_pc_mac got %h want 0", PC_MAC); end
      n_cmp++; if (PC_IP !== 32'h0) begin n_bad++; $display("FAIL reset_pc_ip got %h want 0", PC_IP); end
      n_cmp++; if (req_valid !== 1'b0 || crc_err !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got %b%b want 00", req_valid, crc_err); end
      reset = 1'b0;
      repeat (2) @(negedge clock);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy got %b want 0", busy); end
   endtask

   task automatic test_good_request;
      int r, h, e;
      r = rv_rise; h = rv_hi; e = ce_rise;
      build(BCAST, 16'h0001, 32'hC0A80164, MY_IP, 64);
      send_frame(4, -1, 0);
      n_cmp++; if (rv_rise - r !== 1) begin n_bad++; $display("FAIL good_req_pulses got %0d want 1", rv_rise - r); end
      n_cmp++; if (rv_hi - h !== 1) begin n_bad++; $display("FAIL good_req_width got %0d want 1", rv_hi - h); end
      n_cmp++; if (ce_rise - e !== 0) begin n_bad++; $display("FAIL good_crc_err got %0d want 0", ce_rise - e); end
      n_cmp++; if (PC_MAC !== SHA) begin n_bad++; $display("FAIL good_pc_mac got %h want %h", PC_MAC, SHA); end
      n_cmp++; if (PC_IP !== 32'hC0A80164) begin n_bad++; $display("FAIL good_pc_ip got %h want c0a80164", PC_IP); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL good_busy got %b want 0", busy); end
   endtask

   task automatic test_bad_fcs;
      int r, e, h;
      r = rv_rise; e = ce_rise; h = ce_hi;
      build(BCAST, 16'h0001, 32'hC0A80199, MY_IP, 64);
      frm[62] = frm[62] ^ 8'h01;
      send_frame(4, -1, 0);
      n_cmp++; if (ce_rise - e !== 1) begin n_bad++; $display("FAIL badfcs_crc_pulses got %0d want 1", ce_rise - e); end
      n_cmp++; if (ce_hi - h !== 1) begin n_bad++; $display("FAIL badfcs_crc_width got %0d want 1", ce_hi - h); end
      n_cmp++; if (rv_rise - r !== 0) begin n_bad++; $display("FAIL badfcs_req got %0d want 0", rv_rise - r); end
      n_cmp++; if (PC_IP !== 32'hC0A80164) begin n_bad++; $display("FAIL badfcs_pc_ip got %h want c0a80164", PC_IP); end
   endtask

   task automatic test_no_match;
      int r, e;
      r = rv_rise; e = ce_rise;
      build(BCAST, 16'h0001, 32'hC0A80177, 32'hC0A8010B, 64);
      send_frame(4, -1, 0);
      build(BCAST, 16'h0002, 32'hC0A80177, MY_IP, 64);
      send_frame(4, -1, 0);
      build(48'h02AABBCCDDEF, 16'h0001, 32'hC0A80177, MY_IP, 64);
      send_frame(4, -1, 0);
      n_cmp++; if (rv_rise - r !== 0) begin n_bad++; $display("FAIL nomatch_req got %0d want 0", rv_rise - r); end
      n_cmp++; if (ce_rise - e !== 0) begin n_bad++; $display("FAIL nomatch_crc_err got %0d want 0", ce_rise - e); end
      n_cmp++; if (PC_IP !== 32'hC0A80164) begin n_bad++; $display("FAIL nomatch_pc_ip got %h want c0a80164", PC_IP); end
   endtask

   task automatic test_unicast;
      int r;
      r = rv_rise;
      build(MY_MAC, 16'h0001, 32'hC0A80133, MY_IP, 64);
      send_frame(4, -1, 0);
      n_cmp++; if (rv_rise - r !== 1) begin n_bad++; $display("FAIL unicast_req got %0d want 1", rv_rise - r); end
      n_cmp++; if (PC_IP !== 32'hC0A80133) begin n_bad++; $display("FAIL unicast_pc_ip got %h want c0a80133", PC_IP); end
   endtask

   task automatic test_odd_nibble;
      int r, e;
      r = rv_rise; e = ce_rise;
      build(BCAST, 16'h0001, 32'hC0A80144, MY_IP, 64);
      send_frame(4, -1, 1);
      n_cmp++; if (rv_rise - r !== 0 || ce_rise - e !== 0) begin n_bad++; $display("FAIL odd_pulses got %0d/%0d want 0/0", rv_rise - r, ce_rise - e); end
   endtask

   task automatic test_reset_mid_frame;
      int r;
      r = rv_rise;
      build(BCAST, 16'h0001, 32'hC0A80155, MY_IP, 64);
      send_frame(1, 30, 0);
      n_cmp++; if (busy_at_abort !== 1'b1) begin n_bad++; $display("FAIL abort_busy got %b want 1", busy_at_abort); end
      n_cmp++; if (PC_IP !== 32'h0) begin n_bad++; $display("FAIL abort_pc_ip got %h want 0", PC_IP); end
      build(BCAST, 16'h0001, 32'hC0A80164, MY_IP, 64);
      send_frame(4, -1, 0);
      n_cmp++; if (rv_rise - r !== 1) begin n_bad++; $display("FAIL abort_req got %0d want 1", rv_rise - r); end
      n_cmp++; if (PC_IP !== 32'hC0A80164) begin n_bad++; $display("FAIL abort_pc_ip2 got %h want c0a80164", PC_IP); end
   endtask

   task automatic test_back_to_back;
      int r;
      r = rv_rise;
      build(BCAST, 16'h0001, 32'hC0A80164, MY_IP, 64);
      send_frame(1, -1, 0);
      build(BCAST, 16'h0001, 32'hC0A80165, MY_IP, 64);
      send_frame(4, -1, 0);
      n_cmp++; if (rv_rise - r !== 2) begin n_bad++; $display("FAIL b2b_req got %0d want 2", rv_rise - r); end
      n_cmp++; if (PC_IP !== 32'hC0A80165) begin n_bad++; $display("FAIL b2b_pc_ip got %h want c0a80165", PC_IP); end
   endtask

   task automatic test_length;
      int r, e;
      r = rv_rise; e = ce_rise;
      build(BCAST, 16'h0001, 32'hC0A80111, MY_IP, 60);
      send_frame(4, -1, 0);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL runt_busy got %b want 0", busy); end
      build(BCAST, 16'h0001, 32'hC0A80122, MY_IP, 1519);
      send_frame(4, -1, 0);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL long_busy got %b want 0", busy); end
      n_cmp++; if (rv_rise - r !== 0 || ce_rise - e !== 0) begin n_bad++; $display("FAIL len_pulses got %0d/%0d want 0/0", rv_rise - r, ce_rise - e); end
      build(BCAST, 16'h0001, 32'hC0A80133, MY_IP, 1518);
      send_frame(4, -1, 0);
      n_cmp++; if (rv_rise - r !== 1) begin n_bad++; $display("FAIL maxlen_req got %0d want 1", rv_rise - r); end
      n_cmp++; if (PC_IP !== 32'hC0A80133) begin n_bad++; $display("FAIL maxlen_pc_ip got %h want c0a80133", PC_IP); end
   endtask

   task automatic test_exclusive;
      n_cmp++; if (both_hi !== 0) begin n_bad++; $display("FAIL exclusive_pulses got %0d overlap cycles want 0", both_hi); end
   endtask

   initial begin
      test_reset;
      test_good_request;
      test_bad_fcs;
      test_no_match;
      test_unicast;
      test_odd_nibble;
      test_reset_mid_frame;
      test_back_to_back;
      test_length;
      test_exclusive;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
